// File: rtl/xnor_cmp_sched.sv
// Bit-serial word-compare scheduler: two round-robin requesters share one XNOR2 datapath.
// Optional macro XNOR_CMP_EARLY_EXIT_EN ends a compare at the first mismatching bit.
module xnor_cmp_sched #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             eq,
  output logic [CW-1:0]    match_cnt
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [IW-1:0]    bit_idx;
  logic             last;

  logic grant_id;
  logic bit_match;
  logic last_bit;
  logic finish;

  // On a tie the requester that was not served last wins; otherwise the lone requester.
  always_comb begin
    grant_id  = (req0 && req1) ? ~last : req1;
    bit_match = ~(a_sr[0] ^ b_sr[0]);
    last_bit  = (bit_idx == IW'(WIDTH - 1));
`ifdef XNOR_CMP_EARLY_EXIT_EN
    finish    = last_bit || !bit_match;
`else
    finish    = last_bit;
`endif
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
      eq        <= 1'b0;
      match_cnt <= '0;
      last      <= 1'b1;
      a_sr      <= '0;
      b_sr      <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (req0 || req1) begin
            state     <= SHIFT;
            busy      <= 1'b1;
            a_sr      <= grant_id ? a1 : a0;
            b_sr      <= grant_id ? b1 : b0;
            done_id   <= grant_id;
            last      <= grant_id;
            bit_idx   <= '0;
            eq        <= 1'b1;
            match_cnt <= '0;
          end
        end
        SHIFT: begin
          eq        <= eq & bit_match;
          match_cnt <= match_cnt + CW'(bit_match);
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          bit_idx   <= bit_idx + IW'(1);
          if (finish) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          // Result registers hold until the next grant; only the pulse and busy drop.
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_cmp_sched.sv
// Self-checking bench for xnor_cmp_sched; expected results come from a bitwise
// reference model that also honours XNOR_CMP_EARLY_EXIT_EN when defined.
module tb_xnor_cmp_sched;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             ck;
  logic             rst;
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic             eq;
  logic [CW-1:0]    match_cnt;

  int checks;
  int failures;

  xnor_cmp_sched #(.WIDTH(WIDTH)) dut (
    .ck        (ck),
    .rst       (rst),
    .req0      (req0),
    .a0        (a0),
    .b0        (b0),
    .req1      (req1),
    .a1        (a1),
    .b1        (b1),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .eq        (eq),
    .match_cnt (match_cnt)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Reference: walk bit positions LSB-first; lat is the number of edges after the grant edge until done.
  function automatic void ref_compare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      output logic exp_eq, output int exp_cnt, output int exp_lat);
    bit stopped;
    stopped = 1'b0;
    exp_eq  = 1'b1;
    exp_cnt = 0;
    exp_lat = WIDTH;
    for (int i = 0; i < WIDTH; i++) begin
      if (!stopped) begin
        if (a[i] == b[i]) exp_cnt++;
        else begin
          exp_eq = 1'b0;
`ifdef XNOR_CMP_EARLY_EXIT_EN
          stopped = 1'b1;
          exp_lat = i + 1;
`endif
        end
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pulse_reset();
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    rst = 1'b0;
  endtask

  // One full transaction from an idle block: request, grant, bounded wait for done, release.
  task automatic applyStimulus(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input string tag);
    logic exp_eq;
    int   exp_cnt;
    int   exp_lat;
    int   k;
    bit   seen;
    ref_compare(a, b, exp_eq, exp_cnt, exp_lat);
    @(negedge ck);
    if (id == 1'b0) begin req0 = 1'b1; a0 = a; b0 = b; end
    else            begin req1 = 1'b1; a1 = a; b1 = b; end
    @(posedge ck);
    @(negedge ck);
    checkOutput({tag, ".busy_after_grant"}, {31'd0, busy}, 32'd1);
    checkOutput({tag, ".grant_id"}, {31'd0, done_id}, {31'd0, id});
    seen = 1'b0;
    k    = 0;
    for (int n = 1; n <= WIDTH + 3 && !seen; n++) begin
      @(posedge ck);
      @(negedge ck);
      if (done) begin seen = 1'b1; k = n; end
    end
    checkOutput({tag, ".done_seen"}, {31'd0, seen}, 32'd1);
    checkOutput({tag, ".latency"}, k, exp_lat);
    checkOutput({tag, ".done_id"}, {31'd0, done_id}, {31'd0, id});
    checkOutput({tag, ".eq"}, {31'd0, eq}, {31'd0, exp_eq});
    checkOutput({tag, ".match_cnt"}, {{(32-CW){1'b0}}, match_cnt}, exp_cnt);
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge ck);
    @(negedge ck);
    checkOutput({tag, ".done_one_cycle"}, {31'd0, done}, 32'd0);
    checkOutput({tag, ".busy_idle"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, ".eq_hold"}, {31'd0, eq}, {31'd0, exp_eq});
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             e_eq;
    int               e_cnt;
    int               e_lat;
    int               pulse_cyc[4];
    logic             pulse_id[4];
    logic             pulse_eq[4];
    int               pulse_cnt[4];
    int               npulse;
    int               k;
    bit               seen;

    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #1;
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkOutput("reset.done", {31'd0, done}, 32'd0);
    checkOutput("reset.done_id", {31'd0, done_id}, 32'd0);
    checkOutput("reset.eq", {31'd0, eq}, 32'd0);
    checkOutput("reset.match_cnt", {{(32-CW){1'b0}}, match_cnt}, 32'd0);
    @(negedge ck);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ck);
      checkOutput("idle.busy", {31'd0, busy}, 32'd0);
    end
    checkOutput("idle.done", {31'd0, done}, 32'd0);
    checkOutput("idle.eq", {31'd0, eq}, 32'd0);

    $display("[TB] directed compares");
    applyStimulus(1'b0, 8'hA5, 8'hA5, "equal_a5");
    applyStimulus(1'b1, 8'hF0, 8'h0F, "f0_vs_0f");
    applyStimulus(1'b1, 8'hFF, 8'hFE, "ff_vs_fe");
    applyStimulus(1'b0, 8'h0F, 8'h8F, "msb_only");

    $display("[TB] operand stability");
    @(negedge ck);
    req0 = 1'b1; a0 = 8'h00; b0 = 8'h00;
    @(posedge ck);
    @(posedge ck);
    @(posedge ck);
    @(negedge ck);
    a0   = 8'hFF;
    req0 = 1'b0;
    seen = 1'b0;
    k    = 0;
    for (int n = 3; n <= WIDTH + 3 && !seen; n++) begin
      @(posedge ck);
      @(negedge ck);
      if (done) begin seen = 1'b1; k = n; end
    end
    checkOutput("stable.done_seen", {31'd0, seen}, 32'd1);
    checkOutput("stable.latency", k, WIDTH);
    checkOutput("stable.eq", {31'd0, eq}, 32'd1);
    checkOutput("stable.match_cnt", {{(32-CW){1'b0}}, match_cnt}, WIDTH);
    checkOutput("stable.done_id", {31'd0, done_id}, 32'd0);
    @(posedge ck);
    @(posedge ck);
    @(negedge ck);
    checkOutput("stable.no_regrant", {31'd0, busy}, 32'd0);

    $display("[TB] round robin");
    pulse_reset();
    a0 = 8'h3C; b0 = 8'h3C; a1 = 8'hFF; b1 = 8'hFE;
    req0 = 1'b1; req1 = 1'b1;
    npulse = 0;
    for (int c = 1; c <= 60 && npulse < 4; c++) begin
      @(negedge ck);
      if (done) begin
        pulse_cyc[npulse] = c;
        pulse_id[npulse]  = done_id;
        pulse_eq[npulse]  = eq;
        pulse_cnt[npulse] = int'(match_cnt);
        npulse++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("rr.pulses", npulse, 4);
    for (int i = 0; i < npulse; i++) begin
      if (i % 2 == 0) ref_compare(8'h3C, 8'h3C, e_eq, e_cnt, e_lat);
      else            ref_compare(8'hFF, 8'hFE, e_eq, e_cnt, e_lat);
      checkOutput("rr.done_id", {31'd0, pulse_id[i]}, i % 2);
      checkOutput("rr.eq", {31'd0, pulse_eq[i]}, {31'd0, e_eq});
      checkOutput("rr.match_cnt", pulse_cnt[i], e_cnt);
      if (i > 0) checkOutput("rr.spacing", pulse_cyc[i] - pulse_cyc[i-1], e_lat + 2);
    end

    $display("[TB] reset mid-operation");
    pulse_reset();
    @(negedge ck);
    req1 = 1'b1; a1 = 8'h3C; b1 = 8'h3C;
    @(posedge ck);
    @(posedge ck);
    @(posedge ck);
    @(posedge ck);
    @(negedge ck);
    rst = 1'b1;
    #1;
    checkOutput("midrst.busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst.done", {31'd0, done}, 32'd0);
    checkOutput("midrst.done_id", {31'd0, done_id}, 32'd0);
    checkOutput("midrst.eq", {31'd0, eq}, 32'd0);
    checkOutput("midrst.match_cnt", {{(32-CW){1'b0}}, match_cnt}, 32'd0);
    @(negedge ck);
    checkOutput("midrst.done_held", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(posedge ck);
    @(negedge ck);
    checkOutput("midrst.regrant_busy", {31'd0, busy}, 32'd1);
    checkOutput("midrst.regrant_id", {31'd0, done_id}, 32'd1);
    seen = 1'b0;
    k    = 0;
    for (int n = 1; n <= WIDTH + 3 && !seen; n++) begin
      @(posedge ck);
      @(negedge ck);
      if (done) begin seen = 1'b1; k = n; end
    end
    req1 = 1'b0;
    checkOutput("midrst.done_seen", {31'd0, seen}, 32'd1);
    checkOutput("midrst.latency", k, WIDTH);
    checkOutput("midrst.eq", {31'd0, eq}, 32'd1);
    checkOutput("midrst.match_cnt", {{(32-CW){1'b0}}, match_cnt}, WIDTH);
    @(posedge ck);
    @(negedge ck);

    $display("[TB] randomized compares");
    for (int i = 0; i < 12; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      applyStimulus(1'($urandom_range(0, 1)), ra, rb, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
